mux_scan_ctrl: RTL
==================

# mux_scan_ctrl

Round-robin scan controller that sits directly upstream of the 8:1 byte multiplexer. It drives the mux select, waits a programmable settle time, and samples the selected byte. Each sample is presented on a valid/ready output port tagged with its channel number. Channels are skipped per an enable mask, and the block runs either single-frame or continuous scans.

## Interface
- `DATA_W`, default 8: width of mux data / sample.
- `CH`, default 8: number of mux inputs.
- `SEL_W`, default 3: select width, equal to log2(CH).
- `DWELL_W`, default 4: settle counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request to begin a scan frame.
- `stop`  in  1  request to end scanning at the current frame boundary.
- `cont`  in  1  continuous mode: restart a frame after frame end.
- `ch_mask`  in  CH  channel enable; bit i enables channel i.
- `dwell`  in  DWELL_W  settle cycles inserted between a select change and the sample.
- `sel`  out  SEL_W  to the mux select input.
- `z`  in  DATA_W  from the mux output.
- `out_data`  out  DATA_W  sampled byte.
- `out_ch`  out  SEL_W  channel of `out_data`.
- `out_valid`  out  1  sample available.
- `out_ready`  in  1  consumer accepts the sample.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_done`  out  1  one-cycle pulse after the last channel of a frame is accepted.

## Operation
- States: IDLE, SETTLE, HOLD.
- **IDLE**
  - `start`=1 with `ch_mask`≠0: latch `ch_mask`, `dwell` and `cont`, and clear `stop_pending`.
  - `sel` ← lowest enabled channel, counter ← `dwell`, go to SETTLE.
  - `start` with `ch_mask`=0 is ignored and the block stays in IDLE.
- **SETTLE**
  - Counter>0: decrement.
  - Counter==0: `out_data`←`z`, `out_ch`←`sel`, `out_valid`←1, go to HOLD.
- **HOLD**
  - `out_valid` is held, with data stable, until a cycle where `out_ready`=1.
  - On acceptance, `out_valid`←0, then one of:
    - A higher enabled channel exists in the latched mask: `sel`←next enabled channel, counter←latched dwell, go to SETTLE.
    - No higher channel: pulse `frame_done`. If latched `cont`=1 and `stop_pending`=0, re-latch `ch_mask`/`dwell`/`cont`; if the new mask≠0, `sel`←lowest enabled channel and go to SETTLE, otherwise go to IDLE. In every other case go to IDLE.
- `stop`=1 while `busy` sets `stop_pending`. The current frame always completes; no frame is aborted mid-way.
- `start` while `busy` is ignored.
- Mask and dwell changes mid-frame have no effect until the next latch point.
- Single enabled channel: each frame is exactly one sample.
- `sel` holds its last value in IDLE.

## Timing
- Reset values: `sel`=0, `out_data`=0, `out_ch`=0, `out_valid`=0, `busy`=0, `frame_done`=0, `stop_pending`=0, state IDLE.
- `start` sampled at edge t: `sel` is valid after edge t and `busy`=1 after edge t.
- `z` is sampled at edge t+1+dwell; `out_valid` rises after that edge.
- Handshake at edge h with `out_ready`=1:
  - Next channel: `sel` changes after edge h; its sample is taken at edge h+1+dwell.
  - Last channel: `frame_done` is high for the cycle after edge h, and `busy` drops after edge h (non-cont).
- Minimum throughput: one sample per 2+dwell cycles with `out_ready` held high.
- `out_ready` asserted while `out_valid`=0 has no effect.
- Asynchronous reset mid-frame returns all outputs to reset values immediately; no partial sample is emitted.

## Structure
- Package `mux_scan_pkg`:
  - State enum (IDLE, SETTLE, HOLD).
  - Default constants CH=8, SEL_W=3, DATA_W=8, DWELL_W=4.
- Sub-module `mux_scan_next_ch`: combinational next-channel finder. Inputs are the mask and current channel. Outputs are the next enabled channel strictly above current (`next`, `found`) and the lowest enabled channel (`first`, `any`).
- Top level holds the FSM, dwell counter, output registers and latched configuration.

## Test plan
- Mask 8'hFF, dwell 0, cont 0, `out_ready` tied 1, mux inputs d_i = 8'h10+i → `out_data` 8'h10..8'h17 with `out_ch` 0..7, one sample every 2 cycles. A single `frame_done` pulse follows channel 7, then `busy`=0.
- Mask 8'b1010_0100, dwell 3 → samples from channels 2, 5, 7 only. Each `z` is sampled 4 cycles after its `sel` change.
- `out_ready` held 0 for 10 cycles on channel 0 → `out_valid`, `out_data` and `sel` stay stable; no advance until `out_ready`=1.
- cont=1, mask 8'h01, `stop` pulsed mid-frame → the current sample completes, `frame_done` pulses once, the block returns to IDLE, and no further samples appear.
- `start` with mask 8'h00 → `busy` stays 0 and `out_valid` never asserts. `start` pulsed while busy → the frame is not restarted.
- `rst_n` asserted during SETTLE of channel 4 → all outputs read reset values immediately. After release, `start` with mask 8'h10 produces a single channel-4 sample.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and default sizing for the mux scan controller.
// Contents: FSM state enum and default parameter values used by the top
// and the next-channel finder.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int CH_DEF      = 8;
  localparam int SEL_W_DEF   = 3;
  localparam int DATA_W_DEF  = 8;
  localparam int DWELL_W_DEF = 4;

endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: combinational channel finder over an enable mask.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mask/cur in; next/found = lowest enabled channel strictly above cur;
//        first/any = lowest enabled channel overall.
module mux_scan_next_ch
  import mux_scan_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [CH-1:0]    mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] next,
  output logic             found,
  output logic [SEL_W-1:0] first,
  output logic             any
);

  // Walk from the top down so the last hit written is the lowest index.
  always_comb begin
    next  = '0;
    found = 1'b0;
    first = '0;
    any   = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = SEL_W'(i);
        any   = 1'b1;
        if (i > int'(cur)) begin
          next  = SEL_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin scan of an 8:1 byte mux with programmable settle.
// Latency: sample taken 1+dwell edges after each select change; 2+dwell per sample min.
// Backpressure: out_valid holds with stable data until out_ready; scan stalls meanwhile.
// Ports: start/stop/cont/ch_mask/dwell configure; sel drives the mux, z returns
//        its output; out_data/out_ch/out_valid/out_ready carry samples;
//        busy = not idle; frame_done pulses after the last accepted channel.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CH      = CH_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [CH-1:0]      ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  input  logic [DATA_W-1:0]  z,
  output logic [DATA_W-1:0]  out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done
);

  state_t state, state_nxt;

  logic [DWELL_W-1:0] cnt;
  logic [CH-1:0]      mask_l;
  logic [DWELL_W-1:0] dwell_l;
  logic               cont_l;
  logic               stop_pending;

  // Finder on the latched mask: only the next-above result matters here.
  logic [SEL_W-1:0] lat_next;
  logic             lat_found;
  logic [SEL_W-1:0] lat_first_unused;
  logic             lat_any_unused;

  // Finder on the live mask: only the lowest-channel result matters here,
  // used at latch points (idle start and continuous restart).
  logic [SEL_W-1:0] live_next_unused;
  logic             live_found_unused;
  logic [SEL_W-1:0] live_first;
  logic             live_any;

  mux_scan_next_ch #(.CH(CH), .SEL_W(SEL_W)) u_lat_find (
    .mask  (mask_l),
    .cur   (sel),
    .next  (lat_next),
    .found (lat_found),
    .first (lat_first_unused),
    .any   (lat_any_unused)
  );

  mux_scan_next_ch #(.CH(CH), .SEL_W(SEL_W)) u_live_find (
    .mask  (ch_mask),
    .cur   (sel),
    .next  (live_next_unused),
    .found (live_found_unused),
    .first (live_first),
    .any   (live_any)
  );

  logic start_ok;   // accepted start from IDLE
  logic latch_cfg;  // capture ch_mask/dwell/cont this edge
  logic go_first;   // load sel with lowest live channel, counter with live dwell
  logic go_next;    // advance to next channel of latched mask
  logic do_sample;  // capture z into the output register
  logic accept;     // output handshake this edge
  logic fd_set;     // frame ends this edge

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    latch_cfg = 1'b0;
    go_first  = 1'b0;
    go_next   = 1'b0;
    do_sample = 1'b0;
    accept    = 1'b0;
    fd_set    = 1'b0;
    case (state)
      IDLE: begin
        if (start && live_any) begin
          start_ok  = 1'b1;
          latch_cfg = 1'b1;
          go_first  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          do_sample = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // out_valid is always high in HOLD, so out_ready alone completes it.
        if (out_ready) begin
          accept = 1'b1;
          if (lat_found) begin
            go_next   = 1'b1;
            state_nxt = SETTLE;
          end else begin
            fd_set = 1'b1;
            if (cont_l && !stop_pending) begin
              // Re-latch even if the new mask is empty; that just ends scanning.
              latch_cfg = 1'b1;
              if (live_any) begin
                go_first  = 1'b1;
                state_nxt = SETTLE;
              end else begin
                state_nxt = IDLE;
              end
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel          <= '0;
      cnt          <= '0;
      mask_l       <= '0;
      dwell_l      <= '0;
      cont_l       <= 1'b0;
      stop_pending <= 1'b0;
      out_data     <= '0;
      out_ch       <= '0;
      out_valid    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= fd_set;

      if (latch_cfg) begin
        mask_l  <= ch_mask;
        dwell_l <= dwell;
        cont_l  <= cont;
      end

      if (start_ok) begin
        stop_pending <= 1'b0;
      end else if (stop && (state != IDLE)) begin
        stop_pending <= 1'b1;
      end

      if (go_first) begin
        sel <= live_first;
        cnt <= dwell;
      end else if (go_next) begin
        sel <= lat_next;
        cnt <= dwell_l;
      end else if ((state == SETTLE) && (cnt != '0)) begin
        cnt <= cnt - DWELL_W'(1);
      end

      if (do_sample) begin
        out_data  <= z;
        out_ch    <= sel;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
